// File: rtl/vga_fb_fetch_ctrl.sv
// rtl/vga_fb_fetch_ctrl.sv - framebuffer burst fetch scheduler feeding the VGA pixel stream
// Walks the frame linearly with fixed-length Avalon-MM read bursts into a pixel FIFO.
module vga_fb_fetch_ctrl #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          BURST_LEN  = 16,
  parameter int          FIFO_DEPTH = 64
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        frame_start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [6:0]  avm_burstcount,
  input  logic        avm_waitrequest,
  input  logic [7:0]  avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        pix_req,
  output logic [5:0]  pix_data,
  output logic        underflow,
  output logic        fetch_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  localparam logic [31:0]   TOTAL     = 32'(H_ACTIVE * V_ACTIVE);
  localparam logic [31:0]   BURST32   = 32'(BURST_LEN);
  localparam logic [CW-1:0] BURST_C   = CW'(BURST_LEN);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_REQ   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  logic [2:0]    state;
  logic [31:0]   beats_left;
  logic [BW-1:0] beat_cnt;
  logic [5:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic restart;
  logic fifo_wr;
  logic pop;
  logic last_beat;
  logic unused_bits;

  assign unused_bits    = ^avm_readdata[7:6];
  assign avm_read       = (state == S_REQ);
  assign avm_burstcount = 7'(BURST_LEN);
  assign fetch_busy     = (state != S_IDLE);
  assign last_beat      = (beat_cnt == LAST_BEAT);
  assign pop            = pix_req && (count != '0);

  // restart reloads the frame pointer and empties the FIFO in one cycle
  always_comb begin
    restart = 1'b0;
    fifo_wr = 1'b0;
    case (state)
      S_IDLE:  restart = frame_start;
      S_CHECK: restart = frame_start;
      S_REQ:   restart = frame_start && avm_waitrequest;
      S_DATA: begin
        fifo_wr = avm_readdatavalid && !frame_start;
        restart = frame_start && avm_readdatavalid && last_beat;
      end
      S_FLUSH: restart = avm_readdatavalid && last_beat;
      default: restart = 1'b0;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state       <= S_IDLE;
      avm_address <= BASE_ADDR;
      beats_left  <= '0;
      beat_cnt    <= '0;
    end else if (restart) begin
      state       <= S_CHECK;
      avm_address <= BASE_ADDR;
      beats_left  <= TOTAL;
      beat_cnt    <= '0;
    end else begin
      case (state)
        S_CHECK: begin
          if (beats_left == '0)
            state <= S_IDLE;
          else if ((DEPTH_C - count) >= BURST_C)
            state <= S_REQ;
        end
        S_REQ: begin
          if (!avm_waitrequest) begin
            avm_address <= avm_address + BURST32;
            beats_left  <= beats_left - BURST32;
            beat_cnt    <= '0;
            state       <= frame_start ? S_FLUSH : S_DATA;
          end
        end
        S_DATA: begin
          if (avm_readdatavalid)
            beat_cnt <= beat_cnt + BW'(1);
          if (frame_start) begin
            state <= S_FLUSH;
          end else if (avm_readdatavalid && last_beat) begin
            state    <= S_CHECK;
            beat_cnt <= '0;
          end
        end
        // beats of the abandoned burst are counted off and dropped
        S_FLUSH: begin
          if (avm_readdatavalid)
            beat_cnt <= beat_cnt + BW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (restart) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(fifo_wr) - CW'(pop);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (fifo_wr)
      mem[wr_ptr] <= avm_readdata[5:0];
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pix_data  <= '0;
      underflow <= 1'b0;
    end else if (pix_req) begin
      if (count != '0) begin
        pix_data <= mem[rd_ptr];
      end else begin
        pix_data  <= '0;
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/vga_fb_fetch_ctrl.md
# vga_fb_fetch_ctrl

Framebuffer fetch scheduler between the HPS/DDR3 memory port and the VGA pixel output of the FPGA_VGA system. Issues fixed-length Avalon-MM read bursts to walk the framebuffer linearly, buffers returned pixels in an internal FIFO, and serves one 6-bit RGB222 pixel per request from the VGA timing generator. Restarts at the frame base on every frame-start pulse and flags underflow when the display outruns memory.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- BASE_ADDR, 32'h0000_0000, byte address of pixel 0
- BURST_LEN, 16, beats per read burst (power of 2, 2..64)
- FIFO_DEPTH, 64, pixel FIFO entries (power of 2, ≥ 2*BURST_LEN)

- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse from VGA timing at start of vertical blank
- avm_address  out  32  byte address, one pixel per byte
- avm_read  out  1  read request
- avm_burstcount  out  7  constant BURST_LEN
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  8  pixel byte, bits [5:0] = {R[1:0],G[1:0],B[1:0]}
- avm_readdatavalid  in  1  read beat valid
- pix_req  in  1  pop one pixel
- pix_data  out  6  registered pixel
- underflow  out  1  sticky: pix_req while FIFO empty
- fetch_busy  out  1  high in any state but IDLE

## Operation
- States: IDLE, CHECK, REQ, DATA, FLUSH.
- IDLE: wait frame_start → clear FIFO, address = BASE_ADDR, beats_left = H_ACTIVE*V_ACTIVE → CHECK.
- CHECK: if beats_left == 0 → IDLE; else if free slots ≥ BURST_LEN → REQ.
- REQ: avm_read=1 with avm_address/avm_burstcount stable until sampled with avm_waitrequest=0 → DATA; address += BURST_LEN, beats_left -= BURST_LEN at acceptance.
- DATA: each avm_readdatavalid writes readdata[5:0] to FIFO; after BURST_LEN beats → CHECK. One burst outstanding max.
- frame_start in CHECK/REQ-accepted-none: restart as in IDLE directly. frame_start in DATA (or in REQ on the accept cycle): → FLUSH; remaining beats of current burst are discarded; then clear FIFO, restart as in IDLE.
- frame_start in FLUSH: ignored (restart already pending).
- Pixel side: pix_req with FIFO non-empty pops head into pix_data; pix_req with FIFO empty → pix_data = 0, underflow = 1. pix_req without frame running behaves the same.
- Simultaneous FIFO write and pop: both occur, count unchanged. FIFO never overflows by construction; free-slot check counts current occupancy only (no overlap).
- H_ACTIVE*V_ACTIVE must be a multiple of BURST_LEN; address arithmetic 32-bit, wraps modulo 2^32.

## Timing
- Reset values: avm_read 0, avm_address BASE_ADDR, avm_burstcount BURST_LEN, pix_data 0, underflow 0, fetch_busy 0, state IDLE, FIFO empty.
- frame_start at cycle N → CHECK at N+1; avm_read asserted at N+2 if FIFO has space.
- avm_readdatavalid beat at cycle N → FIFO count increments at N+1.
- pix_req at cycle N → pix_data valid at N+1, held until next pop/underflow.
- underflow sets cycle after offending pix_req; cleared only by reset.
- Reset asserted mid-burst: all state returns to reset values immediately; outstanding beats arriving after reset release in IDLE are ignored.

## Test plan
- Reset release, no frame_start → avm_read stays 0, fetch_busy 0, pix_data 0, underflow 0 for 100 cycles.
- frame_start, slave zero-wait, 4-cycle read latency → first burst at BASE_ADDR, burstcount 16, second at BASE_ADDR+16; FIFO holds 64 after 4 bursts, no 5th issued until pops free ≥16.
- avm_waitrequest held high 10 cycles → avm_read/address/burstcount stable all 10 cycles, single acceptance.
- Small frame (H_ACTIVE=32, V_ACTIVE=2), popped continuously → pixels 0..63 match memory bytes [5:0] in order, fetch ends after 4 bursts, state IDLE, underflow 0.
- frame_start after 5 of 16 beats → 11 beats discarded, FIFO cleared, next burst at BASE_ADDR, first popped pixel = memory byte 0.
- pix_req with empty FIFO → pix_data 0, underflow 1 next cycle and remains 1 after later valid pops.
